// File: rtl/fpadd_ctrl_pkg.sv
// fpadd_ctrl_pkg: FSM state encoding and default sizes for the FP adder controller.
package fpadd_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ALIGN, ADD, NORM, PACK, DONE} seq_state_t;
  localparam int NORM_MAX_CYCLES_DEF = 32;
  localparam int TAG_W_DEF = 4;
endpackage

// File: rtl/fpadd_sat_counter.sv
// fpadd_sat_counter: saturating event counter with synchronous clear (clear wins).
module fpadd_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/fpadd_sequencer.sv
// fpadd_sequencer: multi-cycle stage sequencer for the FP adder datapath.
// Define FPADD_SEQ_STATS_EN to add saturating op/bypass/timeout statistics counters.
module fpadd_sequencer
  import fpadd_ctrl_pkg::*;
#(
  parameter int NORM_MAX_CYCLES = NORM_MAX_CYCLES_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic             norm_timeout,
  input  logic             bypass_alu,
  input  logic             norm_done,
  output logic             ld_operands,
  output logic             en_align,
  output logic             en_add,
  output logic             en_norm,
  output logic             en_pack,
  output logic             sel_bypass
`ifdef FPADD_SEQ_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [31:0]      stat_ops,
  output logic [31:0]      stat_bypass,
  output logic [15:0]      stat_timeouts
`endif
);
  localparam int CW = NORM_MAX_CYCLES > 1 ? $clog2(NORM_MAX_CYCLES) : 1;
  seq_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic byp_q, byp_d, to_q, to_d, cap;
  assign cap = cnt_q == CW'(NORM_MAX_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    tag_d = tag_q;
    byp_d = byp_q;
    to_d = to_q;
    case (state_q)
      IDLE: if (in_valid) begin
        tag_d = in_tag;
        state_d = LOAD;
      end
      LOAD: state_d = ALIGN;
      ALIGN: begin
        byp_d = bypass_alu;
        state_d = bypass_alu ? PACK : ADD;
      end
      ADD: begin
        cnt_d = '0;
        state_d = NORM;
      end
      NORM: begin
        // Hold the count on exit so the cap compare never lets it wrap.
        cnt_d = (norm_done || cap) ? cnt_q : cnt_q + 1'b1;
        state_d = (norm_done || cap) ? PACK : NORM;
        to_d = !norm_done && cap;
      end
      PACK: state_d = DONE;
      DONE: if (out_ready) begin
        state_d = IDLE;
        byp_d = 1'b0;
        to_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tag_q <= '0;
      byp_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tag_q <= tag_d;
      byp_q <= byp_d;
      to_q <= to_d;
    end
  assign in_ready = state_q == IDLE;
  assign ld_operands = state_q == LOAD;
  // bypass_alu only becomes valid in ALIGN, so the align enable must be qualified there.
  assign en_align = state_q == ALIGN && !bypass_alu;
  assign en_add = state_q == ADD;
  assign en_norm = state_q == NORM;
  assign en_pack = state_q == PACK;
  assign out_valid = state_q == DONE;
  assign sel_bypass = byp_q;
  assign norm_timeout = to_q;
  assign out_tag = tag_q;
`ifdef FPADD_SEQ_STATS_EN
  logic hs;
  assign hs = out_valid && out_ready;
  fpadd_sat_counter #(.W(32)) u_ops (.clk(clk), .rst_n(rst_n), .inc_i(hs), .clr_i(stat_clr), .cnt_o(stat_ops));
  fpadd_sat_counter #(.W(32)) u_byp (.clk(clk), .rst_n(rst_n), .inc_i(hs && byp_q), .clr_i(stat_clr), .cnt_o(stat_bypass));
  fpadd_sat_counter #(.W(16)) u_to (.clk(clk), .rst_n(rst_n), .inc_i(hs && to_q), .clr_i(stat_clr), .cnt_o(stat_timeouts));
`endif
endmodule
